// File: rtl/apb_uart_tx.sv
// rtl/apb_uart_tx.sv - APB completer that buffers bytes and sends them as 8N1 UART frames
//
// Purpose:
//   Software programs BAUDDIV and CTRL, then writes bytes to TXDATA. Bytes go
//   into a small FIFO and a four-state serializer (IDLE/START/DATA/STOP)
//   shifts them out LSB first on txd. A TXDATA write to a full FIFO is held
//   with wait states until space frees up, so no data is dropped.
//
// Ports:
//   PCLK     in   1  bus and logic clock, rising edge
//   PRESET   in   1  asynchronous active-high reset
//   PADDR    in  32  byte address (0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV, 0xC CTRL)
//   PSELx    in   1  completer select
//   PENABLE  in   1  access phase
//   PWRITE   in   1  1 = write
//   PWDATA   in  32  write data
//   PREADY   out  1  transfer complete (0 = wait state)
//   PRDATA   out 32  read data, valid in the access phase of a read
//   PSLVERR  out  1  error response for unmapped addresses
//   txd      out  1  serial output, idle high
//   tx_irq   out  1  level interrupt: irq_en & FIFO empty & serializer idle

module apb_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd10
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic        txd,
  output logic        tx_irq
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [4:0]    r_count;

  logic [15:0]   r_baud_div;
  logic          r_en;
  logic          r_irq_en;

  logic [15:0]   r_div_lat;
  logic [15:0]   r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_tx_irq;

  logic          w_access;
  logic          w_addr_ok;
  logic [1:0]    w_reg;
  logic          w_full;
  logic          w_empty;
  logic          w_busy;
  logic          w_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic [15:0]   w_div_eff;
  logic          w_unused;

  // ---------------------------------------------------------------- APB side
  assign w_access  = PSELx & PENABLE;
  assign w_addr_ok = (PADDR[31:4] == 28'd0) && (PADDR[1:0] == 2'b00);
  assign w_reg     = PADDR[3:2];
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == 5'd0);
  assign w_busy    = (r_state != S_IDLE);

  // Wait state only for a TXDATA write while the registered full flag is set.
  // A pop in that same cycle frees space, but the push waits one more edge.
  assign PREADY  = ~(w_access & w_addr_ok & PWRITE & (w_reg == REG_TXDATA) & w_full);
  assign PSLVERR = w_access & ~w_addr_ok;

  assign w_wr   = w_access & PREADY & PWRITE & w_addr_ok;
  assign w_push = w_wr & (w_reg == REG_TXDATA);

  always_comb begin
    PRDATA = 32'd0;
    if (w_access && w_addr_ok && !PWRITE) begin
      unique case (w_reg)
        REG_TXDATA:  PRDATA = 32'd0;
        REG_STATUS:  PRDATA = {19'd0, r_count, 5'd0, w_busy, w_empty, w_full};
        REG_BAUDDIV: PRDATA = {16'd0, r_baud_div};
        REG_CTRL:    PRDATA = {30'd0, r_irq_en, r_en};
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_baud_div <= DIV_RESET;
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
    end else if (w_wr) begin
      if (w_reg == REG_BAUDDIV) begin
        r_baud_div <= PWDATA[15:0];
      end
      if (w_reg == REG_CTRL) begin
        r_en     <= PWDATA[0];
        r_irq_en <= PWDATA[1];
      end
    end
  end

  // -------------------------------------------------------------------- FIFO
  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= PWDATA[7:0];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 5'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------- serializer
  assign w_div_eff = (r_baud_div == 16'd0) ? 16'd1 : r_baud_div;
  assign w_bit_end = (r_baud_cnt == 16'd0);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_en && !w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          // Chain straight into the next frame so there is no idle gap.
          if (r_en && !w_empty) begin
            w_pop        = 1'b1;
            w_next_state = S_START;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_div_lat  <= 16'd1;
      r_baud_cnt <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_txd      <= 1'b1;
      r_tx_irq   <= 1'b0;
    end else begin
      // txd is registered from the current state, so the line lags the
      // state by one cycle; every bit still lasts exactly BAUDDIV cycles.
      unique case (r_state)
        S_START: r_txd <= 1'b0;
        S_DATA:  r_txd <= r_shift[0];
        default: r_txd <= 1'b1;
      endcase
      r_tx_irq <= r_irq_en & w_empty & ~w_busy;

      if (w_pop) begin
        // Divisor is captured per frame so BAUDDIV writes only hit the next one.
        r_shift    <= r_mem[r_rptr];
        r_div_lat  <= w_div_eff;
        r_baud_cnt <= w_div_eff - 16'd1;
        r_bit_idx  <= 3'd0;
      end else if (r_state != S_IDLE) begin
        if (w_bit_end) begin
          r_baud_cnt <= r_div_lat - 16'd1;
          if (r_state == S_DATA) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end else begin
          r_baud_cnt <= r_baud_cnt - 16'd1;
        end
      end
    end
  end

  assign txd    = r_txd;
  assign tx_irq = r_tx_irq;

  assign w_unused = ^PWDATA[31:16];

endmodule

// File: tb/tb_apb_uart_tx.sv
// tb/tb_apb_uart_tx.sv - scoreboard testbench for apb_uart_tx

module tb_apb_uart_tx;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] PADDR;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        txd;
  logic        tx_irq;

  apb_uart_tx dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PSELx   (PSELx),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .txd     (txd),
    .tx_irq  (tx_irq)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t exp_q[$];
  int     start_cycs[$];
  int     frames_done = 0;
  int     cur_div     = 10;
  logic   b_active    = 1'b0;

  // Frame monitor: on a start bit, pop the expected frame and check that each
  // of the 10 bits holds its value for exactly div cycles.
  initial begin
    frame_t     f;
    logic [9:0] bits;
    logic       ok;
    logic       aborted;
    forever begin
      @(negedge PCLK);
      if (!PRESET && txd === 1'b0) begin
        start_cycs.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_val("stray_frame", 32'd1, 32'd0);
          for (int t = 0; t < 1000 && txd !== 1'b1; t++) @(negedge PCLK);
        end else begin
          f       = exp_q.pop_front();
          bits    = {1'b1, f.data, 1'b0};
          aborted = 1'b0;
          for (int b = 0; b < 10 && !aborted; b++) begin
            ok = 1'b1;
            for (int c = 0; c < f.div; c++) begin
              if (b != 0 || c != 0) @(negedge PCLK);
              if (PRESET) begin
                aborted = 1'b1;
                break;
              end
              if (txd !== bits[b]) ok = 1'b0;
            end
            if (!aborted) check_val($sformatf("frame_%02h_bit%0d", f.data, b), {31'd0, ok}, 32'd1);
          end
          if (!aborted) frames_done++;
        end
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits,
                          output int done_cyc);
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    forever begin
      @(negedge PCLK);
      if (!b_active && PREADY === 1'b1) break;
      waits++;
      if (waits > 500) break;
    end
    if (waits > 500) check_val("apb_timeout", 32'd1, 32'd0);
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge PCLK); #1;
    done_cyc = cyc;
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  // Second master: borrows the bus between edges of a stalled transfer and
  // restores the first master's signals afterwards.
  task automatic master_b_write(input logic [31:0] addr, input logic [31:0] data, output int e_cyc);
    logic [31:0] sa, sd;
    logic        ss, se, sw;
    @(posedge PCLK); #1;
    sa = PADDR; sd = PWDATA; ss = PSELx; se = PENABLE; sw = PWRITE;
    b_active = 1'b1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check_val("b_pready", {31'd0, PREADY}, 32'd1);
    @(posedge PCLK); #1;
    e_cyc = cyc;
    PADDR = sa; PWDATA = sd; PSELx = ss; PENABLE = se; PWRITE = sw;
    b_active = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd_d;
    logic        e;
    int          w, dc;
    apb_xfer(1'b1, addr, data, rd_d, e, w, dc);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd_d;
    logic        e;
    int          w, dc;
    apb_xfer(1'b0, addr, 32'd0, rd_d, e, w, dc);
    check_val(tag, rd_d, exp);
  endtask

  task automatic push_byte(input logic [7:0] d, output int done_cyc);
    logic [31:0] rd_d;
    logic        e;
    int          w;
    exp_q.push_back('{d, cur_div});
    apb_xfer(1'b1, 32'h0, {24'd0, d}, rd_d, e, w, done_cyc);
  endtask

  task automatic wait_frames(input int n);
    for (int t = 0; t < 5000 && frames_done < n; t++) @(negedge PCLK);
    check_val("frames_done", frames_done, n);
  endtask

  task automatic wait_starts(input int n);
    for (int t = 0; t < 5000 && start_cycs.size() < n; t++) @(negedge PCLK);
    check_val("start_seen", start_cycs.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_d;
    logic        e;
    int          w, dc, n_push, e_cyc, a_done, a_waits, s1, s2, lows;

    PRESET = 1'b1; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'd0; PWDATA = 32'd0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_val("rst_txd", {31'd0, txd}, 32'd1);
    check_val("rst_pready", {31'd0, PREADY}, 32'd1);
    check_val("rst_prdata", PRDATA, 32'd0);
    check_val("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check_val("rst_irq", {31'd0, tx_irq}, 32'd0);
    @(posedge PCLK); #1 PRESET = 1'b0;
    rd_chk("rst_status", 32'h4, 32'h2);
    rd_chk("rst_bauddiv", 32'h8, 32'd10);
    rd_chk("rst_ctrl", 32'hC, 32'd0);

    // Single frame 0xA5 at BAUDDIV=4
    wr(32'h8, 32'd4); cur_div = 4;
    wr(32'hC, 32'd1);
    start_cycs.delete();
    push_byte(8'hA5, n_push);
    repeat (6) @(posedge PCLK);
    apb_xfer(1'b0, 32'h4, 32'd0, rd_d, e, w, dc);
    check_val("busy_mid_frame", rd_d & 32'h4, 32'h4);
    wait_frames(1);
    check_val("push_to_start", start_cycs[0] - n_push, 32'd2);
    rd_chk("status_after_frame", 32'h4, 32'h2);
    @(negedge PCLK);
    check_val("txd_idle_after", {31'd0, txd}, 32'd1);

    // Error responses and ignored STATUS write
    apb_xfer(1'b0, 32'h10, 32'd0, rd_d, e, w, dc);
    check_val("err_rd_pslverr", {31'd0, e}, 32'd1);
    check_val("err_rd_prdata", rd_d, 32'd0);
    check_val("err_rd_nowait", w, 32'd0);
    apb_xfer(1'b1, 32'h6, 32'hFF, rd_d, e, w, dc);
    check_val("err_wr6_pslverr", {31'd0, e}, 32'd1);
    apb_xfer(1'b1, 32'hA, 32'h1234, rd_d, e, w, dc);
    check_val("err_wrA_pslverr", {31'd0, e}, 32'd1);
    rd_chk("bauddiv_unchanged", 32'h8, 32'd4);
    apb_xfer(1'b1, 32'hE, 32'h0, rd_d, e, w, dc);
    rd_chk("ctrl_unchanged", 32'hC, 32'd1);
    apb_xfer(1'b1, 32'h4, 32'hFFFF, rd_d, e, w, dc);
    check_val("status_wr_noerr", {31'd0, e}, 32'd0);
    rd_chk("status_wr_ignored", 32'h4, 32'h2);

    // Full FIFO, stalled 9th write, second master enables the serializer
    wr(32'hC, 32'd0);
    wr(32'h8, 32'd2); cur_div = 2;
    for (int i = 0; i < 8; i++) push_byte(8'(i * 17 + 3), dc);
    rd_chk("status_full", 32'h4, 32'h801);
    exp_q.push_back('{8'h5A, 2});
    fork
      apb_xfer(1'b1, 32'h0, 32'h5A, rd_d, e, a_waits, a_done);
      begin
        repeat (25) @(posedge PCLK);
        master_b_write(32'hC, 32'd1, e_cyc);
      end
    join
    check_val("stall_waits_ge20", {31'd0, (a_waits >= 20)}, 32'd1);
    check_val("stall_done_cycle", a_done - e_cyc, 32'd2);
    rd_chk("status_refull", 32'h4, 32'h805);
    wait_frames(10);

    // Back-to-back frames and interrupt timing
    wr(32'hC, 32'd0);
    push_byte(8'h00, dc);
    push_byte(8'hFF, dc);
    start_cycs.delete();
    wr(32'hC, 32'd3);
    wait_starts(1);
    check_val("irq_low_in_frame", {31'd0, tx_irq}, 32'd0);
    wait_starts(2);
    s1 = start_cycs[0];
    s2 = start_cycs[1];
    check_val("b2b_gap", s2 - s1, 32'd20);
    for (int t = 0; t < 100 && cyc < s2 + 19; t++) @(negedge PCLK);
    check_val("irq_before_stop_end", {31'd0, tx_irq}, 32'd0);
    @(negedge PCLK);
    check_val("irq_after_stop_end", {31'd0, tx_irq}, 32'd1);
    wait_frames(12);

    // Reset in the middle of a frame
    wr(32'hC, 32'd1);
    wr(32'h8, 32'd4); cur_div = 4;
    start_cycs.delete();
    push_byte(8'h00, dc);
    push_byte(8'h00, dc);
    wait_starts(1);
    s1 = start_cycs[0];
    for (int t = 0; t < 100 && cyc < s1 + 13; t++) @(negedge PCLK);
    check_val("txd_bit3_low", {31'd0, txd}, 32'd0);
    @(posedge PCLK); #2 PRESET = 1'b1;
    exp_q.delete();
    #1 check_val("txd_async_high", {31'd0, txd}, 32'd1);
    @(posedge PCLK); #1 PRESET = 1'b0;
    rd_chk("status_after_rst", 32'h4, 32'h2);
    rd_chk("bauddiv_after_rst", 32'h8, 32'd10);
    wr(32'hC, 32'd1);
    lows = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge PCLK);
      if (txd !== 1'b1) lows++;
    end
    check_val("no_frame_after_rst", lows, 32'd0);
    check_val("frames_after_rst", frames_done, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
